// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment path: store funct3 encodings,
// FSM state type and the access-size byte mask helper.
package store_align_unit_pkg;

    localparam logic [2:0] SB_F3 = 3'b000;
    localparam logic [2:0] SH_F3 = 3'b001;
    localparam logic [2:0] SW_F3 = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } store_state_t;

    // Byte mask of the access before lane shifting; zero marks an illegal funct3.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] m;
        case (funct3)
            SB_F3:   m = 4'b0001;
            SH_F3:   m = 4'b0011;
            SW_F3:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align_unit_lane_gen.sv
// store_lane_gen: purely combinational lane math for one store request.
// Produces the word-aligned beat0 address/data/strobes and flags an illegal
// funct3. With STORE_MISALIGN_SPLIT_EN the second beat of a word-crossing
// store and the cross flag are produced; otherwise a misalign flag is.
module store_lane_gen
    import store_align_unit_pkg::*;
#(
    parameter  int WIDTH  = 32,
    localparam int NBYTES = WIDTH / 8
) (
    input  logic [WIDTH-1:0]  addr,
    input  logic [2:0]        funct3,
    input  logic [WIDTH-1:0]  data,
    output logic [WIDTH-1:0]  b0_addr,
    output logic [WIDTH-1:0]  b0_wdata,
    output logic [NBYTES-1:0] b0_be,
    output logic              illegal,
`ifdef STORE_MISALIGN_SPLIT_EN
    output logic [WIDTH-1:0]  b1_addr,
    output logic [WIDTH-1:0]  b1_wdata,
    output logic [NBYTES-1:0] b1_be,
    output logic              cross
`else
    output logic              misalign
`endif
);

    logic [1:0]        off;
    logic [NBYTES-1:0] mask;

    assign off     = addr[1:0];
    assign mask    = size_mask(funct3);
    assign illegal = (mask == '0);
    assign b0_addr = {addr[WIDTH-1:2], 2'b00};

`ifdef STORE_MISALIGN_SPLIT_EN
    // Shift into a double-width window: the upper half is exactly what
    // spills into the next word, so beat1 falls out of the same shift.
    logic [2*WIDTH-1:0]  wd_wide;
    logic [2*NBYTES-1:0] be_wide;

    assign wd_wide  = {{WIDTH{1'b0}}, data} << {off, 3'b000};
    assign be_wide  = {{NBYTES{1'b0}}, mask} << off;
    assign b0_wdata = wd_wide[WIDTH-1:0];
    assign b1_wdata = wd_wide[2*WIDTH-1:WIDTH];
    assign b0_be    = be_wide[NBYTES-1:0];
    assign b1_be    = be_wide[2*NBYTES-1:NBYTES];
    assign cross    = |be_wide[2*NBYTES-1:NBYTES];
    assign b1_addr  = b0_addr + WIDTH'(4);
`else
    assign b0_wdata = data << {off, 3'b000};
    assign b0_be    = mask << off;
    assign misalign = ((funct3 == SH_F3) && off[0]) ||
                      ((funct3 == SW_F3) && (off != 2'b00));
`endif

endmodule

// File: rtl/store_align_unit.sv
// store_align_unit: turns a RISC-V store request into one or two word-aligned
// write beats on a valid/ready memory port, pulsing done when the store is
// fully written or err when the request is rejected.
// Optional feature macro: STORE_MISALIGN_SPLIT_EN -- when defined, stores that
// cross a word boundary are split into two beats; when undefined, misaligned
// SH/SW are rejected with err and no beat is issued.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter  int WIDTH  = 32,
    localparam int NBYTES = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_addr,
    input  logic [WIDTH-1:0]  req_data,
    input  logic [2:0]        req_funct3,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [NBYTES-1:0] mem_be,
    output logic              done,
    output logic              err
);

    store_state_t      state;
    logic              accept;
    logic              reject;
    logic [WIDTH-1:0]  g_b0_addr;
    logic [WIDTH-1:0]  g_b0_wdata;
    logic [NBYTES-1:0] g_b0_be;
    logic              g_illegal;

`ifdef STORE_MISALIGN_SPLIT_EN
    logic [WIDTH-1:0]  g_b1_addr;
    logic [WIDTH-1:0]  g_b1_wdata;
    logic [NBYTES-1:0] g_b1_be;
    logic              g_cross;
    logic              cross_q;
    logic [WIDTH-1:0]  b1_addr_q;
    logic [WIDTH-1:0]  b1_wdata_q;
    logic [NBYTES-1:0] b1_be_q;
`else
    logic              g_misalign;
`endif

    store_lane_gen #(.WIDTH(WIDTH)) u_lane_gen (
        .addr     (req_addr),
        .funct3   (req_funct3),
        .data     (req_data),
        .b0_addr  (g_b0_addr),
        .b0_wdata (g_b0_wdata),
        .b0_be    (g_b0_be),
        .illegal  (g_illegal),
`ifdef STORE_MISALIGN_SPLIT_EN
        .b1_addr  (g_b1_addr),
        .b1_wdata (g_b1_wdata),
        .b1_be    (g_b1_be),
        .cross    (g_cross)
`else
        .misalign (g_misalign)
`endif
    );

`ifdef STORE_MISALIGN_SPLIT_EN
    assign reject = g_illegal;
`else
    assign reject = g_illegal | g_misalign;
`endif

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;

    // FSM plus registered write port; done/err are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            cross_q    <= 1'b0;
            b1_addr_q  <= '0;
            b1_wdata_q <= '0;
            b1_be_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_addr  <= g_b0_addr;
                            mem_wdata <= g_b0_wdata;
                            mem_be    <= g_b0_be;
                            state     <= ST_BEAT0;
`ifdef STORE_MISALIGN_SPLIT_EN
                            cross_q    <= g_cross;
                            b1_addr_q  <= g_b1_addr;
                            b1_wdata_q <= g_b1_wdata;
                            b1_be_q    <= g_b1_be;
`endif
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                        if (cross_q) begin
                            mem_addr  <= b1_addr_q;
                            mem_wdata <= b1_wdata_q;
                            mem_be    <= b1_be_q;
                            state     <= ST_BEAT1;
                        end else
`endif
                        begin
                            mem_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
`ifdef STORE_MISALIGN_SPLIT_EN
                ST_BEAT1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    mem_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Testbench for store_align_unit: directed spec scenarios followed by random
// stores, each checked against a byte-level model of where every source byte
// lands in memory.
module tb_store_align_unit;

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_funct3;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beats for the current request
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    int          m_n;
    bit          m_err;

    store_align_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_funct3 (req_funct3),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Byte-level model: source byte j sits at byte address addr+j; the word
    // it falls in picks the beat, its low address bits pick the lane.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int size;
        int off;
        int pos;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            default: size = 0;
        endcase
        off = int'(a[1:0]);
        if (size == 0) m_err = 1'b1;
        else           m_err = !SPLIT && ((a % 32'(size)) != 0);
        m_n = 0;
        for (int b = 0; b < 2; b++) begin
            m_addr[b]  = (a & ~32'h3) + 32'(4 * b);
            m_wdata[b] = '0;
            m_be[b]    = '0;
        end
        if (!m_err) begin
            m_n = (off + size > 4) ? 2 : 1;
            for (int j = 0; j < 4; j++) begin
                pos = off + j;
                if (pos / 4 < m_n) begin
                    m_wdata[pos / 4][8 * (pos % 4) +: 8] = d[8 * j +: 8];
                    if (j < size) m_be[pos / 4][pos % 4] = 1'b1;
                end
            end
        end
    endtask

    // Issue one store at the current negedge and follow it to done/err.
    // hold: cycles mem_ready is forced low on the first beat; stall: random backpressure.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input bit stall, input int hold, input string name);
        int          k;
        int          cyc;
        int          hold_cnt;
        bit          fin;
        bit          prev_stall;
        logic [31:0] pa;
        logic [31:0] pw;
        logic [3:0]  pb;
        model(a, d, f3);
        chk({name, ".req_ready_idle"}, req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_funct3 = f3;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_data   = $urandom;
        req_funct3 = 3'($urandom);
        k          = 0;
        fin        = 1'b0;
        prev_stall = 1'b0;
        hold_cnt   = hold;
        pa = '0; pw = '0; pb = '0;
        for (cyc = 1; cyc <= 100 && !fin; cyc++) begin
            chk({name, ".done_err_excl"}, done & err, 0);
            if (err) begin
                chk({name, ".err"}, err, m_err);
                chk({name, ".err_cycle"}, cyc, 1);
                chk({name, ".err_req_ready"}, req_ready, 1);
                chk({name, ".err_beats"}, k, 0);
                fin = 1'b1;
            end else if (done) begin
                chk({name, ".done"}, done, !m_err);
                chk({name, ".beats"}, k, m_n);
                if (!stall && hold == 0) chk({name, ".latency"}, cyc, m_n + 1);
                fin = 1'b1;
            end else if (mem_valid) begin
                chk({name, ".beat_expected"}, k < m_n, 1);
                if (k < m_n) begin
                    chk({name, ".addr"},  mem_addr,  m_addr[k]);
                    chk({name, ".wdata"}, mem_wdata, m_wdata[k]);
                    chk({name, ".be"},    mem_be,    m_be[k]);
                end
                chk({name, ".req_ready_busy"}, req_ready, 0);
                if (prev_stall) begin
                    chk({name, ".hold_addr"},  mem_addr,  pa);
                    chk({name, ".hold_wdata"}, mem_wdata, pw);
                    chk({name, ".hold_be"},    mem_be,    pb);
                end
                if (hold_cnt > 0) begin
                    mem_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    mem_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                prev_stall = !mem_ready;
                pa = mem_addr;
                pw = mem_wdata;
                pb = mem_be;
                if (mem_ready) k++;
            end else begin
                chk({name, ".mem_valid_gap"}, mem_valid, 1);
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) chk({name, ".timeout"}, fin, 1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_funct3 = '0;
        mem_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.mem_valid", mem_valid, 0);
        chk("rst.mem_addr",  mem_addr,  0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.mem_be",    mem_be,    0);
        chk("rst.done",      done,      0);
        chk("rst.err",       err,       0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.req_ready", req_ready, 1);
        chk("post_rst.mem_valid", mem_valid, 0);

        // Aligned and sub-word stores
        run_store(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 1'b0, 0, "sw_aligned");
        run_store(32'h0000_0103, 32'h0000_00A5, 3'b000, 1'b0, 0, "sb_off3");
        run_store(32'h0000_0102, 32'h0000_1234, 3'b001, 1'b0, 0, "sh_off2");
        // Misaligned: split or rejected depending on build
        run_store(32'h0000_0101, 32'h1122_3344, 3'b010, 1'b0, 0, "sw_off1");
        run_store(32'h0000_0102, 32'hCAFE_F00D, 3'b010, 1'b0, 0, "sw_off2");
        run_store(32'h0000_0101, 32'h0000_ABCD, 3'b001, 1'b0, 0, "sh_off1");
        run_store(32'h0000_0103, 32'h5566_7788, 3'b001, 1'b0, 0, "sh_off3");
        run_store(32'hFFFF_FFFD, 32'h0102_0304, 3'b010, 1'b0, 0, "sw_wrap");
        // Illegal funct3
        run_store(32'h0000_0100, 32'h1234_5678, 3'b011, 1'b0, 0, "f3_011");
        run_store(32'h0000_0200, 32'h1234_5678, 3'b111, 1'b0, 0, "f3_111");
        // Backpressure on beat0
        run_store(32'h0000_0300, 32'hA1B2_C3D4, 3'b010, 1'b0, 5, "stall5");
        run_store(32'h0000_0301, 32'h0BAD_F00D, 3'b010, 1'b0, 3, "stall3_split");

        // Reset while a beat is waiting for mem_ready
        mem_ready  = SPLIT;
        req_valid  = 1'b1;
        req_addr   = SPLIT ? 32'h0000_0101 : 32'h0000_0200;
        req_data   = 32'h1122_3344;
        req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid.beat0_valid", mem_valid, 1);
        if (SPLIT) begin
            @(negedge clk);
            chk("rstmid.beat1_be",   mem_be,   4'b0001);
            chk("rstmid.beat1_addr", mem_addr, 32'h0000_0104);
            mem_ready = 1'b0;
        end
        @(negedge clk);
        chk("rstmid.waiting", mem_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.mem_valid", mem_valid, 0);
        chk("rstmid.done",      done,      0);
        chk("rstmid.err",       err,       0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid.no_done",  done,      0);
            chk("rstmid.no_valid", mem_valid, 0);
        end
        mem_ready = 1'b1;
        run_store(32'h0000_0000, 32'h0000_005A, 3'b000, 1'b0, 0, "sb_after_rst");

        // Random stores with random backpressure
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            logic [31:0] rd;
            logic [2:0]  rf;
            ra = $urandom;
            rd = $urandom;
            if ($urandom_range(0, 9) < 8) rf = 3'($urandom_range(0, 2));
            else                          rf = 3'($urandom_range(3, 7));
            run_store(ra, rd, rf, 1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
